fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32: instruction memory size in 32-bit words (power of two, 2..1024).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013: bubble encoding (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port stall  input  1: hold PC and IF/ID register (hazard unit).
REQ-007 SHALL have port flush  input  1: load bubble into IF/ID.
REQ-008 SHALL have port redirect  input  1: taken branch/jump resolved downstream.
REQ-009 SHALL have port redirect_pc  input  32: target for redirect.
REQ-010 SHALL have port imem_we  input  1: bench/loader write enable for instruction memory.
REQ-011 SHALL have port imem_waddr  input  log2(IMEM_DEPTH): word address of write.
REQ-012 SHALL have port imem_wdata  input  32: instruction word to write.
REQ-013 SHALL have port if_pc  output  32: current fetch PC.
REQ-014 SHALL have port id_pc  output  32: PC of instruction held in IF/ID.
REQ-015 SHALL have port id_instr  output  32: instruction held in IF/ID, feeding decode/control.
REQ-016 SHALL have port id_valid  output  1: IF/ID holds a real (non-bubble) instruction.
REQ-017 SHALL have port fetch_fault  output  1: sticky out-of-range fetch flag (see Configuration).

Function
REQ-018 SHALL read imem combinationally at word index if_pc[log2(IMEM_DEPTH)+1:2]; fetch-to-IF/ID latency exactly one cycle.
REQ-019 SHALL, per cycle, apply priority rst > redirect > stall > normal advance for the PC.
REQ-020 SHALL on normal advance set if_pc <= if_pc+4 (modulo 2^32 wrap) and IF/ID <= {if_pc, fetched word, valid=1}.
REQ-021 SHALL on redirect set if_pc <= redirect_pc with bits [1:0] forced to 0, and load IF/ID with {id_pc=0, NOP_INSTR, valid=0}, regardless of stall or flush.
REQ-022 SHALL on stall without redirect hold if_pc and hold IF/ID unchanged, unless flush is also high.
REQ-023 SHALL on flush without redirect load IF/ID with bubble {0, NOP_INSTR, 0}; PC advances if stall low, holds if stall high.
REQ-024 SHALL treat if_pc >= 4*IMEM_DEPTH as out of range: fetched word = NOP_INSTR, valid = 0.
REQ-025 SHALL write imem_wdata into imem[imem_waddr] on rising edge when imem_we=1, including while rst=1; a same-cycle fetch of that word returns the old contents.
REQ-026 SHALL never produce X on outputs after the first reset edge, even with unwritten imem words (imem initialised to NOP_INSTR at time zero).

Reset
REQ-027 SHALL on rst=1 at a rising edge set if_pc=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0, fetch_fault=0.
REQ-028 SHALL not clear imem contents on reset.
REQ-029 SHALL give rst priority over redirect, stall and flush when asserted mid-operation; fetch resumes at RESET_PC the cycle after rst deasserts.

Configuration
REQ-030 SHALL with macro FETCH_BOUND_TRAP_EN defined: on an out-of-range fetch set fetch_fault=1 (sticky until rst) and freeze if_pc, inserting bubbles, until rst or a redirect to an in-range PC (fetch_fault stays 1).
REQ-031 SHALL with FETCH_BOUND_TRAP_EN undefined: tie fetch_fault to 0 and keep advancing if_pc per REQ-020/REQ-024.

Verification
REQ-032 SHALL cover: load imem[0..3]=0x00500093,0x00A00113,0x002081B3,0x00000013, pulse rst -> cycle after reset id_pc=0,id_instr=0x00500093,id_valid=1; next id_pc=4,id_instr=0x00A00113.
REQ-033 SHALL cover: stall=1 for 2 cycles at if_pc=8 -> if_pc stays 8, IF/ID unchanged for both cycles, advances to 12 after release.
REQ-034 SHALL cover: redirect=1, redirect_pc=0x0000000E with stall=1 -> next if_pc=0x0000000C, id_instr=0x00000013, id_valid=0.
REQ-035 SHALL cover: stall=1 and flush=1 at if_pc=4 -> if_pc stays 4, id_valid=0, id_instr=0x00000013.
REQ-036 SHALL cover: IMEM_DEPTH=32, run to if_pc=0x80 -> id_valid=0; with FETCH_BOUND_TRAP_EN fetch_fault=1 and if_pc holds 0x80; without it fetch_fault=0 and if_pc=0x84 next cycle.
REQ-037 SHALL cover: rst=1 asserted while redirect=1 to 0x40 -> next if_pc=RESET_PC=0, id_valid=0, fetch_fault=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with an internal instruction memory
// and the IF/ID pipeline register.
//
// Optional feature macro: FETCH_BOUND_TRAP_EN
//   defined   -> an out-of-range fetch sets a sticky fetch_fault and freezes
//                the PC (bubbles issued) until rst or a redirect.
//   undefined -> fetch_fault is tied low; the PC keeps advancing through
//                out-of-range addresses, which fetch as invalid bubbles.
//
// Parameters:
//   IMEM_DEPTH  instruction memory depth in 32-bit words (power of two, 2..1024)
//   RESET_PC    PC loaded on reset
//   NOP_INSTR   bubble encoding
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   stall                 hold PC and IF/ID
//   flush                 load a bubble into IF/ID
//   redirect, redirect_pc taken branch/jump target (word aligned on load)
//   imem_we/waddr/wdata   instruction memory write port (works during rst)
//   if_pc                 current fetch PC
//   id_pc/instr/valid     IF/ID register contents
//   fetch_fault           sticky out-of-range fetch flag
module fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   if_pc,
    output logic [31:0]                   id_pc,
    output logic [31:0]                   id_instr,
    output logic                          id_valid,
    output logic                          fetch_fault
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    // Memory starts out holding bubbles so unwritten words never read as X.
    // It is deliberately not touched by rst.
    logic [31:0] imem [IMEM_DEPTH] = '{default: NOP_INSTR};

    logic          in_range;
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic          freeze;

    logic [31:0]   pc_d;
    logic [31:0]   id_pc_d;
    logic [31:0]   id_instr_d;
    logic          id_valid_d;

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Asynchronous read: a same-edge write is seen only on the next cycle.
    assign in_range   = (if_pc[31:AW+2] == '0);
    assign fetch_idx  = if_pc[AW+1:2];
    assign fetch_word = in_range ? imem[fetch_idx] : NOP_INSTR;

`ifdef FETCH_BOUND_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (!redirect && !in_range) begin
            fault_q <= 1'b1;
        end
    end

    // Freeze tracks the current PC, so a redirect to an in-range target
    // resumes fetching while the fault flag itself stays set.
    assign freeze      = !in_range;
    assign fetch_fault = fault_q;
`else
    assign freeze      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Priority below rst: redirect > stall > advance. Flush only affects IF/ID.
    always_comb begin
        pc_d       = if_pc;
        id_pc_d    = id_pc;
        id_instr_d = id_instr;
        id_valid_d = id_valid;
        if (redirect) begin
            pc_d       = redirect_pc & ~32'd3;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else begin
            if (!stall && !freeze) begin
                pc_d = if_pc + 32'd4;
            end
            if (flush || (freeze && !stall)) begin
                id_pc_d    = '0;
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end else if (!stall) begin
                id_pc_d    = if_pc;
                id_instr_d = fetch_word;
                id_valid_d = in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc    <= RESET_PC;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else begin
            if_pc    <= pc_d;
            id_pc    <= id_pc_d;
            id_instr <= id_instr_d;
            id_valid <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_BOUND_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        fetch_fault;

    fetch_stage #(
        .IMEM_DEPTH(32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .if_pc      (if_pc),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_if_pc;
        logic [31:0] e_id_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] if_pc;
        logic [31:0] id_pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[$];

    function automatic logic [31:0] w(input int unsigned i);
        case (i)
            0: w = 32'h0050_0093;
            1: w = 32'h00A0_0113;
            2: w = 32'h0020_81B3;
            3: w = 32'h0000_0013;
            default: w = 32'h0100_0000 + i;
        endcase
    endfunction

    function automatic vec_t v(input logic r, st, fl, rd, input logic [31:0] rpc,
                               input logic [31:0] eif, eid, ein, input logic ev, ef);
        vec_t x;
        x.rst = r; x.stall = st; x.flush = fl; x.redirect = rd; x.rpc = rpc;
        x.we = 1'b0; x.waddr = '0; x.wdata = '0;
        x.e_if_pc = eif; x.e_id_pc = eid; x.e_instr = ein;
        x.e_valid = ev; x.e_fault = ef;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one vector, queue its expectation, clock once, compare after the edge.
    task automatic apply(input string name, input vec_t x);
        exp_t e;
        e.name = name; e.if_pc = x.e_if_pc; e.id_pc = x.e_id_pc;
        e.instr = x.e_instr; e.valid = x.e_valid; e.fault = x.e_fault;
        rst = x.rst; stall = x.stall; flush = x.flush; redirect = x.redirect;
        redirect_pc = x.rpc; imem_we = x.we; imem_waddr = x.waddr; imem_wdata = x.wdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".if_pc"},    if_pc,               e.if_pc);
        chk({e.name, ".id_pc"},    id_pc,               e.id_pc);
        chk({e.name, ".id_instr"}, id_instr,            e.instr);
        chk({e.name, ".id_valid"}, {31'd0, id_valid},    {31'd0, e.valid});
        chk({e.name, ".fault"},    {31'd0, fetch_fault}, {31'd0, e.fault});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t x;

        // Load the program while reset is held.
        for (int unsigned i = 0; i < 32; i++) begin
            rst = 1'b1; imem_we = 1'b1; imem_waddr = i[4:0]; imem_wdata = w(i);
            @(posedge clk);
            #1;
        end
        apply("reset", v(1, 0, 0, 0, 0, 32'h0, 32'h0, NOP, 0, 0));

        // {rst, stall, flush, redirect, redirect_pc, exp if_pc, id_pc, instr, valid, fault}
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h04, 32'h00, w(0), 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h08, 32'h04, w(1), 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,            32'h08, 32'h04, w(1), 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,            32'h08, 32'h04, w(1), 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h0C, 32'h08, w(2), 1, 0));
        vecs.push_back(v(0, 1, 0, 1, 32'h0E,       32'h0C, 32'h00, NOP,  0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h10, 32'h0C, w(3), 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 32'h04,       32'h04, 32'h00, NOP,  0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0,            32'h04, 32'h00, NOP,  0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0,            32'h08, 32'h00, NOP,  0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h0C, 32'h08, w(2), 1, 0));
        vecs.push_back(v(0, 0, 1, 1, 32'h7C,       32'h7C, 32'h00, NOP,  0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h80, 32'h7C, w(31), 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,            TRAP ? 32'h80 : 32'h84,
                         TRAP ? 32'h00 : 32'h80, NOP, 0, TRAP));
        vecs.push_back(v(0, 0, 0, 0, 0,            TRAP ? 32'h80 : 32'h88,
                         TRAP ? 32'h00 : 32'h84, NOP, 0, TRAP));
        vecs.push_back(v(0, 0, 0, 1, 32'h08,       32'h08, 32'h00, NOP,  0, TRAP));
        vecs.push_back(v(0, 0, 0, 0, 0,            32'h0C, 32'h08, w(2), 1, TRAP));

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Reset wins over redirect/stall/flush; fetch resumes at RESET_PC.
        apply("rst_over_redirect", v(1, 1, 1, 1, 32'h40, 32'h00, 32'h00, NOP, 0, 0));
        apply("after_rst",         v(0, 0, 0, 0, 0,      32'h04, 32'h00, w(0), 1, 0));

        // Write to the word being fetched: old contents go to IF/ID.
        x = v(0, 0, 0, 0, 0, 32'h08, 32'h04, w(1), 1, 0);
        x.we = 1'b1; x.waddr = 5'd1; x.wdata = 32'hDEAD_BEEF;
        apply("wr_same_cycle", x);
        apply("wr_redirect",   v(0, 0, 0, 1, 32'h04, 32'h04, 32'h00, NOP, 0, 0));
        apply("wr_new_word",   v(0, 0, 0, 0, 0,      32'h08, 32'h04, 32'hDEAD_BEEF, 1, 0));

        // Top of the address space: wraps without the trap, freezes with it.
        apply("wrap_redirect", v(0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, NOP, 0, 0));
        apply("wrap_step1",    v(0, 0, 0, 0, 0, TRAP ? 32'hFFFF_FFFC : 32'h0,
                                 TRAP ? 32'h0 : 32'hFFFF_FFFC, NOP, 0, TRAP));
        apply("wrap_step2",    v(0, 0, 0, 0, 0, TRAP ? 32'hFFFF_FFFC : 32'h4,
                                 32'h0, TRAP ? NOP : w(0), !TRAP, TRAP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
